pc_sequencer: RTL and testbench

Fetch-stage controller owning the program counter of the RV32I core. Sequences the PC (sequential +4, branch/jump redirect, trap entry), issues one instruction-memory request at a time, and hands the returned instruction with its PC and PC+4 to decode under a valid/ready handshake. It sits between the instruction memory port and the decode stage.

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 57 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the RV32I fetch-stage PC sequencer.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } state_e;

   localparam logic [31:0] NOP                  = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority select (trap > redirect > pending > sequential) and redirect alignment check.
// PC_MISALIGN_TRAP_EN: misaligned redirect targets become traps instead of being force-aligned.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_req,
   input  logic        pend_valid,
   input  logic        pend_trap,
   input  logic [31:0] pend_target,
   output logic [31:0] seq_pc,
   output logic        merged_valid,
   output logic        merged_trap,
   output logic [31:0] merged_target,
   output logic [31:0] next_pc,
   output logic        misalign
);

   logic        evt_valid;
   logic        evt_trap;
   logic [31:0] evt_target;
   logic        redirect_misaligned;

`ifdef PC_MISALIGN_TRAP_EN
   assign redirect_misaligned = redirect_valid && !trap_req && (redirect_target[1:0] != 2'b00);
`else
   logic [1:0] unused_low_bits;
   assign unused_low_bits     = redirect_target[1:0];
   assign redirect_misaligned = 1'b0;
`endif

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      evt_valid  = trap_req || redirect_valid;
      evt_trap   = trap_req || redirect_misaligned;
      evt_target = evt_trap ? TRAP_VECTOR : {redirect_target[31:2], 2'b00};

      merged_valid  = pend_valid;
      merged_trap   = pend_valid && pend_trap;
      merged_target = pend_target;
      // A pending trap is never displaced by a later plain redirect.
      if (evt_valid && (evt_trap || !(pend_valid && pend_trap))) begin
         merged_valid  = 1'b1;
         merged_trap   = evt_trap;
         merged_target = evt_target;
      end
   end

   assign seq_pc   = pc + 32'd4;
   assign next_pc  = merged_valid ? merged_target : seq_pc;
   assign misalign = redirect_misaligned;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: one outstanding imem request, valid/ready hand-off to decode.
// Optional PC_MISALIGN_TRAP_EN (see pc_next_sel) turns misaligned redirects into traps.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pcplus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_req,
   output logic        misalign_exc
);

   state_e      state, state_n;
   logic [31:0] pc, pc_n;
   logic        pend_valid, pend_valid_n;
   logic        pend_trap, pend_trap_n;
   logic [31:0] pend_target, pend_target_n;
   logic        capture;

   logic [31:0] seq_pc;
   logic        merged_valid;
   logic        merged_trap;
   logic [31:0] merged_target;
   logic [31:0] next_pc;
   logic        misalign;

   pc_next_sel #(
      .TRAP_VECTOR(TRAP_VECTOR)
   ) u_next_sel (
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .trap_req       (trap_req),
      .pend_valid     (pend_valid),
      .pend_trap      (pend_trap),
      .pend_target    (pend_target),
      .seq_pc         (seq_pc),
      .merged_valid   (merged_valid),
      .merged_trap    (merged_trap),
      .merged_target  (merged_target),
      .next_pc        (next_pc),
      .misalign       (misalign)
   );

   // The fetch address is the PC register itself, so it holds steady until a grant.
   assign imem_addr = pc;

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      pend_valid_n  = 1'b0;
      pend_trap_n   = 1'b0;
      pend_target_n = pend_target;
      capture       = 1'b0;

      unique case (state)
         IDLE: begin
            state_n = REQ;
            if (merged_valid) pc_n = merged_target;
         end
         REQ: begin
            pend_valid_n  = merged_valid;
            pend_trap_n   = merged_trap;
            pend_target_n = merged_target;
            if (imem_gnt) state_n = WAIT;
         end
         WAIT: begin
            pend_valid_n  = merged_valid;
            pend_trap_n   = merged_trap;
            pend_target_n = merged_target;
            if (imem_rvalid) begin
               pend_valid_n = 1'b0;
               pend_trap_n  = 1'b0;
               // A pending redirect means the returning word is stale: drop it and refetch.
               if (merged_valid) begin
                  pc_n    = merged_target;
                  state_n = REQ;
               end else begin
                  capture = 1'b1;
                  state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (merged_valid || if_ready) begin
               pc_n    = next_pc;
               state_n = REQ;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_VECTOR;
         pend_valid   <= 1'b0;
         pend_trap    <= 1'b0;
         pend_target  <= RESET_VECTOR;
         imem_req     <= 1'b0;
         if_valid     <= 1'b0;
         if_instr     <= NOP;
         if_pc        <= RESET_VECTOR;
         if_pcplus4   <= RESET_VECTOR + 32'd4;
         misalign_exc <= 1'b0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         pend_valid   <= pend_valid_n;
         pend_trap    <= pend_trap_n;
         pend_target  <= pend_target_n;
         imem_req     <= (state_n == REQ);
         if_valid     <= (state_n == HOLD);
         misalign_exc <= misalign;
         if (capture) begin
            if_instr   <= imem_rdata;
            if_pc      <= pc;
            if_pcplus4 <= seq_pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic against a protocol-level model.
module tb_pc_sequencer;

   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam logic [31:0] NOP_W    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pcplus4;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_req;
   logic        misalign_exc;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model, expressed as protocol phases rather than an encoded state.
   logic        m_idle, m_ask, m_fly, m_show, m_mis;
   logic [31:0] m_fetch, m_instr, m_pc, m_pc4;
   logic        p_on, p_trap;
   logic [31:0] p_tgt;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pcplus4     (if_pcplus4),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .trap_req       (trap_req),
      .misalign_exc   (misalign_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_ask = 1'b0; m_fly = 1'b0; m_show = 1'b0; m_mis = 1'b0;
      m_fetch = 32'h0; m_instr = NOP_W; m_pc = 32'h0; m_pc4 = 32'h4;
      p_on = 1'b0; p_trap = 1'b0; p_tgt = 32'h0;
   endtask

   task automatic model_step();
      logic        ev, ev_trap, mis;
      logic [31:0] ev_tgt;
      logic [31:0] rt;
      rt      = redirect_target;
      ev      = trap_req || redirect_valid;
      ev_trap = trap_req;
      mis     = 1'b0;
      ev_tgt  = {rt[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
      if (!trap_req && redirect_valid && rt[1:0] != 2'b00) begin
         mis     = 1'b1;
         ev_trap = 1'b1;
      end
`endif
      if (ev_trap) ev_tgt = TRAP_VEC;
      m_mis = mis;

      if (m_idle) begin
         m_idle = 1'b0;
         m_ask  = 1'b1;
         if (ev) m_fetch = ev_tgt;
      end else if (m_show) begin
         if (ev) begin
            m_show = 1'b0; m_ask = 1'b1; m_fetch = ev_tgt;
         end else if (if_ready) begin
            m_show = 1'b0; m_ask = 1'b1; m_fetch = m_fetch + 32'd4;
         end
      end else begin
         if (ev && (ev_trap || !(p_on && p_trap))) begin
            p_on = 1'b1; p_trap = ev_trap; p_tgt = ev_tgt;
         end
         if (m_ask) begin
            if (imem_gnt) begin
               m_ask = 1'b0; m_fly = 1'b1;
            end
         end else if (imem_rvalid) begin
            m_fly = 1'b0;
            if (p_on) begin
               m_ask = 1'b1; m_fetch = p_tgt; p_on = 1'b0; p_trap = 1'b0;
            end else begin
               m_show = 1'b1; m_instr = imem_rdata; m_pc = m_fetch; m_pc4 = m_fetch + 32'd4;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("imem_req",     32'(imem_req),     32'(m_ask));
      check("imem_addr",    imem_addr,         m_fetch);
      check("if_valid",     32'(if_valid),     32'(m_show));
      check("if_instr",     if_instr,          m_instr);
      check("if_pc",        if_pc,             m_pc);
      check("if_pcplus4",   if_pcplus4,        m_pc4);
      check("misalign_exc", 32'(misalign_exc), 32'(m_mis));
   endtask

   task automatic drive(input logic g, input logic rv, input logic rdy,
                        input logic redir, input logic [31:0] tgt, input logic trp);
      imem_gnt        = g;
      imem_rvalid     = rv;
      imem_rdata      = $urandom;
      if_ready        = rdy;
      redirect_valid  = redir;
      redirect_target = tgt;
      trap_req        = trp;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      model_reset();
      @(negedge clk);
      compare_all();
      check("rst_instr_nop", if_instr, 32'h0000_0013);
      check("rst_pcplus4", if_pcplus4, 32'h0000_0004);
      rst_n = 1'b1;

      // Zero-wait memory with decode always ready.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick(); check("zw_req0", 32'(imem_req), 32'd1); check("zw_addr0", imem_addr, 32'h0);
      tick(); check("zw_wait_valid", 32'(if_valid), 32'd0);
      tick(); check("zw_valid", 32'(if_valid), 32'd1); check("zw_pc0", if_pc, 32'h0);
      check("zw_pc4", if_pcplus4, 32'h4);
      tick(); check("zw_addr4", imem_addr, 32'h4);

      // Grant held off three cycles, redirect to 0x40 while waiting.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0); tick();
      check("dly_addr_stable", imem_addr, 32'h4);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      check("dly_addr_stable2", imem_addr, 32'h4); check("dly_req", 32'(imem_req), 32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      check("dly_dropped", 32'(if_valid), 32'd0); check("dly_addr40", imem_addr, 32'h40);

      // Redirect coinciding with rvalid.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b0); tick();
      check("rv_redir_valid", 32'(if_valid), 32'd0); check("rv_redir_addr", imem_addr, 32'h80);

      // Trap and redirect together while holding an instruction.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      check("hold_pc80", if_pc, 32'h80);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1); tick();
      check("trap_addr", imem_addr, 32'h100); check("trap_drop", 32'(if_valid), 32'd0);

      // Misaligned redirect while holding.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0); tick();
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_pulse", 32'(misalign_exc), 32'd1); check("mis_addr", imem_addr, 32'h100);
`else
      check("mis_pulse", 32'(misalign_exc), 32'd0); check("mis_addr", imem_addr, 32'h40);
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      check("mis_one_cycle", 32'(misalign_exc), 32'd0);

      // PC wrap at the top of the address space.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      check("wrap_pc", if_pc, 32'hFFFF_FFFC); check("wrap_pc4", if_pcplus4, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); tick();
      check("wrap_addr", imem_addr, 32'h0);

      // Reset while a response is outstanding; the late rvalid must be ignored.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      reset_pulse();
      tick(); check("rst_wait_addr", imem_addr, 32'h0); check("rst_wait_req", 32'(imem_req), 32'd1);
      tick(); check("rst_wait_novalid", 32'(if_valid), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                            : ($urandom & 32'h0000_0FFF);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
               1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0),
               tgt, 1'($urandom_range(0, 24) == 0));
         if ($urandom_range(0, 199) == 0) reset_pulse();
         else tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
